// File: rtl/c432_key_ctrl.sv
// Key-load and oracle-query sequencer for a key-locked c432 core.
// Loads the key MSB chunk first, then serialises queries through a settle window.
module c432_key_ctrl #(
  parameter int KEY_W      = 64,
  parameter int CHUNK_W    = 8,
  parameter int SETTLE_CYC = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_start,
  input  logic               kd_valid,
  input  logic [CHUNK_W-1:0] kd_data,
  output logic               kd_ready,
  output logic [KEY_W-1:0]   key,
  output logic               key_valid,
  output logic               busy,
  input  logic               q_valid,
  input  logic [35:0]        q_in,
  output logic               q_ready,
  output logic [35:0]        core_in,
  input  logic [6:0]         core_out,
  output logic               r_valid,
  output logic [6:0]         r_out,
  input  logic               r_ready
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_READY  = 3'd2;
  localparam logic [2:0] S_SETTLE = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  localparam int NBEATS = KEY_W / CHUNK_W;
  localparam int BW     = $clog2(NBEATS) + 1;
  localparam logic [BW-1:0] BEAT_LAST   = BW'(NBEATS - 1);
  localparam logic [7:0]    SETTLE_INIT = 8'(SETTLE_CYC);

  logic [2:0]    state;
  logic [BW-1:0] beat;
  logic [7:0]    scnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      key       <= '0;
      key_valid <= 1'b0;
      core_in   <= '0;
      r_valid   <= 1'b0;
      r_out     <= '0;
      beat      <= '0;
      scnt      <= '0;
    end else if (load_start) begin
      // Abort from any state: the old key and any pending response are discarded.
      state     <= S_LOAD;
      key       <= '0;
      key_valid <= 1'b0;
      core_in   <= '0;
      r_valid   <= 1'b0;
      beat      <= '0;
      scnt      <= '0;
    end else begin
      case (state)
        S_IDLE: ;
        S_LOAD: begin
          if (kd_valid) begin
            key  <= {key[KEY_W-CHUNK_W-1:0], kd_data};
            beat <= beat + BW'(1);
            if (beat == BEAT_LAST) begin
              state     <= S_READY;
              key_valid <= 1'b1;
            end
          end
        end
        S_READY: begin
          if (q_valid) begin
            core_in <= q_in;
            scnt    <= SETTLE_INIT;
            state   <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          scnt <= scnt - 8'd1;
          if (scnt == 8'd1) begin
            r_out   <= core_out;
            r_valid <= 1'b1;
            state   <= S_RESP;
          end
        end
        S_RESP: begin
          if (r_ready) begin
            r_valid <= 1'b0;
            state   <= S_READY;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    kd_ready = (state == S_LOAD);
    q_ready  = (state == S_READY);
    busy     = (state == S_LOAD) || (state == S_SETTLE) || (state == S_RESP);
  end

endmodule

// File: tb/tb_c432_key_ctrl.sv
// Bench for c432_key_ctrl: flag/timestamp reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_c432_key_ctrl;
  localparam int SC = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_start = 1'b0;
  logic        kd_valid = 1'b0;
  logic [7:0]  kd_data = '0;
  logic        kd_ready;
  logic [63:0] key;
  logic        key_valid;
  logic        busy;
  logic        q_valid = 1'b0;
  logic [35:0] q_in = '0;
  logic        q_ready;
  logic [35:0] core_in;
  logic [6:0]  core_out;
  logic        r_valid;
  logic [6:0]  r_out;
  logic        r_ready = 1'b0;
  bit          force55 = 1'b0;

  int errors = 0;
  int checks = 0;

  logic [7:0] kb [8] = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};

  c432_key_ctrl #(.KEY_W(64), .CHUNK_W(8), .SETTLE_CYC(SC)) dut (
    .clk(clk), .rst(rst), .load_start(load_start),
    .kd_valid(kd_valid), .kd_data(kd_data), .kd_ready(kd_ready),
    .key(key), .key_valid(key_valid), .busy(busy),
    .q_valid(q_valid), .q_in(q_in), .q_ready(q_ready),
    .core_in(core_in), .core_out(core_out),
    .r_valid(r_valid), .r_out(r_out), .r_ready(r_ready)
  );

  always #5 clk = ~clk;

  // Stand-in for the locked core: an arbitrary key-dependent mixing function.
  function automatic logic [6:0] fold(input logic [35:0] c, input logic [63:0] k);
    logic [63:0] x;
    logic [6:0]  r;
    x = {c[27:0], c} ^ k;
    r = {6'b0, x[63]};
    for (int i = 0; i < 9; i++) r = {r[5:0], r[6]} ^ x[i*7 +: 7];
    return r;
  endfunction

  assign core_out = force55 ? 7'h55 : fold(core_in, key);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: activity flags plus an absolute due-cycle for the response.
  bit          m_load = 0, m_kv = 0, m_set = 0, m_rv = 0;
  int          m_beats = 0;
  logic [63:0] m_key = '0;
  logic [35:0] m_cin = '0;
  logic [6:0]  m_rout = '0;
  longint      cyc = 0, due = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_load = 0; m_kv = 0; m_set = 0; m_rv = 0; m_beats = 0;
      m_key = '0; m_cin = '0; m_rout = '0; cyc = 0;
    end else begin
      cyc++;
      if (load_start) begin
        m_load = 1; m_kv = 0; m_set = 0; m_rv = 0; m_beats = 0;
        m_key = '0; m_cin = '0;
      end else if (m_load) begin
        if (kd_valid) begin
          m_key = (m_key << 8) | 64'(kd_data);
          m_beats++;
          if (m_beats == 8) begin m_load = 0; m_kv = 1; end
        end
      end else if (m_set) begin
        if (cyc == due) begin
          m_rout = force55 ? 7'h55 : fold(m_cin, m_key);
          m_rv = 1; m_set = 0;
        end
      end else if (m_rv) begin
        if (r_ready) m_rv = 0;
      end else if (m_kv) begin
        if (q_valid) begin m_cin = q_in; m_set = 1; due = cyc + SC; end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("key", key, m_key);
      chk("key_valid", 64'(key_valid), 64'(m_kv));
      chk("kd_ready", 64'(kd_ready), 64'(m_load));
      chk("q_ready", 64'(q_ready), 64'(m_kv && !m_set && !m_rv));
      chk("busy", 64'(busy), 64'(m_load || m_set || m_rv));
      chk("core_in", 64'(core_in), 64'(m_cin));
      chk("r_valid", 64'(r_valid), 64'(m_rv));
      chk("r_out", 64'(r_out), 64'(m_rout));
    end
  end

  task automatic load_key(input bit stall, output logic kv_pre);
    int n = 0;
    int k = 0;
    kv_pre = 1'b1;
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    while (n < 8) begin
      kd_valid = stall ? ((k % 3) == 0) : 1'b1;
      kd_data  = kd_valid ? kb[n] : 8'($urandom);
      if (n == 7 && kd_valid) kv_pre = key_valid;
      @(negedge clk);
      if (kd_valid) n++;
      k++;
    end
    kd_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1);
  end

  initial begin
    logic kvp;
    repeat (3) @(negedge clk);
    chk("rst_key", key, 64'h0);
    chk("rst_key_valid", 64'(key_valid), 64'h0);
    chk("rst_core_in", 64'(core_in), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    rst = 1'b0;

    // Query and key beats while IDLE are ignored
    q_valid = 1'b1; q_in = 36'hA_BCDE_1234; kd_valid = 1'b1; kd_data = 8'h77;
    repeat (3) @(negedge clk);
    chk("idle_q_ready", 64'(q_ready), 64'h0);
    chk("idle_core_in", 64'(core_in), 64'h0);
    chk("idle_r_valid", 64'(r_valid), 64'h0);
    kd_valid = 1'b0;

    // Gapless load with q_valid held throughout LOAD
    load_key(1'b0, kvp);
    q_valid = 1'b0;
    chk("load_kv_before_last", 64'(kvp), 64'h0);
    chk("load_key", key, 64'h0123456789ABCDEF);
    chk("load_key_valid", 64'(key_valid), 64'h1);
    chk("load_core_in", 64'(core_in), 64'h0);
    chk("load_r_valid", 64'(r_valid), 64'h0);
    @(negedge clk);
    chk("load_kd_ready_after", 64'(kd_ready), 64'h0);

    // Default-settle query, core forced to 7'h55
    force55 = 1'b1; q_in = '0; q_valid = 1'b1; r_ready = 1'b0;
    @(negedge clk);
    q_valid = 1'b0;
    for (int i = 1; i < SC; i++) begin
      @(negedge clk);
      chk("settle_r_valid", 64'(r_valid), 64'h0);
    end
    @(negedge clk);
    chk("resp_r_valid", 64'(r_valid), 64'h1);
    chk("resp_r_out", 64'(r_out), 64'h55);
    repeat (3) begin
      @(negedge clk);
      chk("resp_hold", 64'(r_valid), 64'h1);
    end
    r_ready = 1'b1;
    @(negedge clk);
    chk("resp_clear", 64'(r_valid), 64'h0);
    chk("resp_q_ready", 64'(q_ready), 64'h1);
    force55 = 1'b0; r_ready = 1'b0;

    // Randomised traffic including aborts and stalled key loads
    for (int i = 0; i < 500; i++) begin
      q_valid    = 1'($urandom_range(0, 1));
      q_in       = 36'({$urandom(), $urandom()});
      r_ready    = ($urandom_range(0, 3) != 0);
      kd_valid   = 1'($urandom_range(0, 1));
      kd_data    = 8'($urandom);
      load_start = ($urandom_range(0, 79) == 0);
      @(negedge clk);
    end
    load_start = 1'b0; q_valid = 1'b0; kd_valid = 1'b0; r_ready = 1'b0;

    // Stalled load must give the same key, then abort during RESP
    load_key(1'b1, kvp);
    chk("stall_key", key, 64'h0123456789ABCDEF);
    chk("stall_key_valid", 64'(key_valid), 64'h1);
    q_in = 36'h9_8765_4321; q_valid = 1'b1;
    @(negedge clk);
    q_valid = 1'b0;
    repeat (SC) @(negedge clk);
    chk("abort_pre_r_valid", 64'(r_valid), 64'h1);
    load_start = 1'b1; r_ready = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    chk("abort_r_valid", 64'(r_valid), 64'h0);
    chk("abort_key", key, 64'h0);
    chk("abort_kd_ready", 64'(kd_ready), 64'h1);
    chk("abort_key_valid", 64'(key_valid), 64'h0);
    repeat (3) @(negedge clk);
    chk("abort_no_resp", 64'(r_valid), 64'h0);
    r_ready = 1'b0;

    // Asynchronous reset in the middle of SETTLE
    load_key(1'b0, kvp);
    q_in = 36'h5_A5A5_A5A5; q_valid = 1'b1;
    @(negedge clk);
    q_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_busy", 64'(busy), 64'h1);
    #2 rst = 1'b1;
    #1;
    chk("arst_key", key, 64'h0);
    chk("arst_key_valid", 64'(key_valid), 64'h0);
    chk("arst_core_in", 64'(core_in), 64'h0);
    chk("arst_r_valid", 64'(r_valid), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", 64'(busy), 64'h0);
    chk("post_rst_kd_ready", 64'(kd_ready), 64'h0);
    chk("post_rst_q_ready", 64'(q_ready), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/c432_key_ctrl.md
# c432_key_ctrl

Sequencer wrapped around a key-locked c432 instance (36 data inputs, 7 outputs, 64 key inputs). It loads the 64-bit key from a byte-wide key store into a holding register, drives the core's key inputs only once loading is complete, and serialises oracle queries through the combinational core. Each query is held stable for a programmable settle window before its outputs are captured. It sits between the attack/test harness and the locked netlist in the simulation platform.

## Interface
- `KEY_W`, 64: key width; must be a multiple of `CHUNK_W`.
- `CHUNK_W`, 8: key-store beat width.
- `SETTLE_CYC`, 4: cycles `core_in` is held before capture; legal range 1..255.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `load_start` in 1: one-cycle pulse that starts a key load and aborts any query in flight.
- `kd_valid` in 1 / `kd_data` in `CHUNK_W` / `kd_ready` out 1: key-store beat handshake, MSB chunk first.
- `key` out `KEY_W`: drives the core keyinputs; bit i drives keyinput i.
- `key_valid` out 1: the full key is loaded and the block accepts queries.
- `busy` out 1: high in LOAD, SETTLE or RESP.
- `q_valid` in 1 / `q_in` in 36 / `q_ready` out 1: query handshake; `q_in[35:0]` maps to G1gat..G115gat in port order, with bit 35 = G1gat.
- `core_in` out 36: registered drive to the core data inputs.
- `core_out` in 7: core outputs {G223,G329,G370,G421,G430,G431,G432}, with bit 6 = G223.
- `r_valid` out 1 / `r_out` out 7 / `r_ready` in 1: response handshake.

## Operation
- States:
  - IDLE: no key loaded.
  - LOAD: collecting key beats.
  - READY: accepting queries.
  - SETTLE: holding `core_in`.
  - RESP: presenting a response.
- Reset values: state=IDLE; `key`=0; `key_valid`=0; `kd_ready`=0; `q_ready`=0; `core_in`=0; `r_valid`=0; `r_out`=0; `busy`=0; beat and settle counters=0.
- IDLE -> LOAD on `load_start`.
  - On entry to LOAD: `key` and `core_in` are cleared to 0, `key_valid`=0, and the beat counter is cleared.
- LOAD:
  - `kd_ready`=1.
  - Each accepted beat (`kd_valid & kd_ready`) shifts in from the LSB end: `key <= {key[KEY_W-CHUNK_W-1:0], kd_data}`. The first beat therefore ends up in `key[63:56]`.
  - After the `KEY_W/CHUNK_W`-th beat (8 by default), go to READY and set `key_valid`=1 on the same edge.
  - `load_start` while in LOAD restarts the load: the key is cleared and the beat count returns to 0.
- READY:
  - `q_ready`=1.
  - On `q_valid & q_ready`: `core_in <= q_in`, the settle counter loads `SETTLE_CYC`, and the state goes to SETTLE.
- SETTLE:
  - The counter decrements each cycle.
  - When the counter reaches 1: `r_out <= core_out`, `r_valid <= 1`, and the state goes to RESP.
- RESP:
  - `r_valid` and `r_out` are held until `r_ready`.
  - On `r_valid & r_ready`: `r_valid <= 0` and the state returns to READY.
  - `core_in` keeps the last query value; it is not re-cleared.
- `load_start` in READY, SETTLE or RESP: go to LOAD immediately. Any pending response is discarded (`r_valid <= 0`), `key_valid` drops and the key is cleared. No response is ever produced with a key other than the one that was active when the query was accepted.
- `kd_valid` outside LOAD is ignored. `q_valid` outside READY is ignored (`q_ready`=0).
- `key` changes only in LOAD. While `key_valid`=0, `core_in` never takes a query value.

## Timing
- Key load: with `kd_valid` held high, LOAD takes exactly `KEY_W/CHUNK_W` cycles. `key_valid` rises on the edge that accepts the last beat.
- Query latency: if the query is accepted at edge T, `core_in` is new from T and `r_valid` rises at edge T+`SETTLE_CYC`. `r_out` is `core_out` sampled at that edge.
- Back-to-back queries:
  - `q_ready` is high again the cycle after the response handshake.
  - Throughput is one query per `SETTLE_CYC`+2 cycles when `r_ready` is held high.
- No combinational paths from inputs to outputs. All outputs are registered or decoded from state.
- `rst` asserted at any time: all outputs return to their reset values immediately, without waiting for a clock edge.

## Test plan
- Reset mid-SETTLE:
  - Stimulus: assert `rst` during SETTLE.
  - Required: `key`=0, `key_valid`=0, `core_in`=0 and `r_valid`=0 before the next clock edge; the state is IDLE after release.
- Key load:
  - Stimulus: `load_start`, then beats 0x01,0x23,..,0xEF with `kd_valid` held high.
  - Required: `key`=64'h0123456789ABCDEF and `key_valid`=1 exactly 8 cycles after the first accepted beat; `kd_ready`=0 afterwards.
- Query with default settle:
  - Stimulus: `SETTLE_CYC`=4, query `q_in`=36'h0_0000_0000 accepted at edge T, with the core model returning 7'h55.
  - Required: `r_valid` rises at T+4 with `r_out`=7'h55; it is held for 3 cycles of `r_ready`=0, then clears the cycle after `r_ready`=1.
- Abort during RESP:
  - Stimulus: `load_start` while in RESP.
  - Required: `r_valid` drops, the key is cleared and `kd_ready`=1 on the next cycle; the old response is never handshaken.
- Key-store stall:
  - Stimulus: `kd_valid` toggled 1,0,0,1,… during the load.
  - Required: only accepted beats are counted; the final `key` is identical to the gapless load.
- Illegal query before key:
  - Stimulus: `q_valid`=1 while in IDLE or LOAD.
  - Required: `q_ready`=0, `core_in` stays 0, and no response is produced.
